picomips_sweep_driver: RTL and testbench
========================================

Name: picomips_sweep_driver

Overview:
Synthesizable, parametrised successor to the picoMIPS switch-stimulus bench: sweeps an address range onto the SW data and handshake lines of a picoMIPS core and checks each LED result against an expected-value memory. Adds programmable setup/strobe/settle timing, signed tolerance comparison, continuous mode, abort, and error and first-failure capture. Sits between a picoMIPS DUT (on board or in simulation) and a synchronous expected-value ROM.

Parameters:
DATA_W, 8, width of sw_data, dut_result and exp_data
ADDR_LO, 0, first sweep address
ADDR_HI, 254, last sweep address (ADDR_HI >= ADDR_LO, both < 2**DATA_W)
SETUP_CYCLES, 10, cycles sw_data is stable with strobe low before strobe (>= 1)
HOLD_CYCLES, 30, cycles strobe is held high (>= 1)
SETTLE_CYCLES, 5, cycles after strobe falls before result sample (>= 2)
TOL, 0, allowed absolute signed difference |dut_result - exp_data|
CNT_W, 16, width of vec_count and err_count

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE
abort  input  1  synchronous; returns to IDLE
cont_mode  input  1  1 = wrap to ADDR_LO after ADDR_HI and keep sweeping
sw_data  output  DATA_W  stimulus value to the DUT (SW[7:0] equivalent)
sw_strobe  output  1  handshake to the DUT (SW[8] equivalent)
dut_result  input  DATA_W  signed DUT output (LED)
exp_addr  output  DATA_W  address to the expected-value ROM
exp_data  input  DATA_W  signed ROM data, valid 1 cycle after exp_addr changes
busy  output  1  high in any state other than IDLE and DONE
done  output  1  high in DONE
vec_count  output  CNT_W  vectors checked, saturating
err_count  output  CNT_W  vectors failing, saturating
fail_seen  output  1  at least one failure since the last start
first_fail_addr  output  DATA_W  address of first failure since the last start

Behaviour:
- Reset (n_reset low, asynchronous): state IDLE; sw_data = exp_addr = ADDR_LO; sw_strobe 0; busy 0; done 0; vec_count, err_count, first_fail_addr 0; fail_seen 0. Reset mid-sweep drops sw_strobe immediately.
- States: IDLE, SETUP, STROBE, SETTLE, CHECK, DONE. All outputs registered.
- IDLE/DONE + start: clear counters, fail_seen and first_fail_addr; addr = ADDR_LO; -> SETUP. start in any other state is ignored.
- SETUP: sw_data = exp_addr = addr, sw_strobe 0, stays exactly SETUP_CYCLES cycles -> STROBE.
- STROBE: sw_strobe 1 for exactly HOLD_CYCLES cycles -> SETTLE.
- SETTLE: sw_strobe 0 for SETTLE_CYCLES cycles; on the last cycle, register dut_result and exp_data -> CHECK.
- CHECK (1 cycle): diff = sign-extend both to DATA_W+1 bits and subtract; fail if |diff| > TOL. vec_count += 1; on fail, err_count += 1; on the first fail, also set fail_seen and capture addr. Counters saturate at all-ones.
- After CHECK: addr < ADDR_HI -> addr+1, SETUP. addr == ADDR_HI: cont_mode 1 -> addr = ADDR_LO, SETUP (counters kept); else -> DONE.
- Per-vector period = SETUP_CYCLES + HOLD_CYCLES + SETTLE_CYCLES + 1 (46 at defaults).
- abort (any state, priority over start and over transitions): next state IDLE; sw_strobe 0 next cycle; counters and fail capture retained; done 0.
- ADDR_LO == ADDR_HI: single-vector sweep.
- sw_data and exp_addr never change while sw_strobe is high.

Test Plan:
- Reset pulse low 10 ns at t=5 ns -> all outputs at reset values; sw_strobe 0; no state change without start.
- Defaults, model DUT returns rom[addr], start -> 255 vectors, done after 255*46 cycles (+1 from start); vec_count 255, err_count 0, fail_seen 0.
- DUT corrupts addr 7 (+3) and addr 200 (-1), TOL=0 -> err_count 2, first_fail_addr 7; with TOL=3 -> err_count 0.
- Signed edge: exp_data 0x7F, dut_result 0x80, TOL=1 -> fail (diff -255, not 1).
- cont_mode=1, ADDR_LO=250, ADDR_HI=254 -> after vector 254 sw_data returns to 250; vec_count 10 after two passes; done never asserts.
- abort asserted in STROBE of vector 3 -> sw_strobe 0 next cycle, IDLE, vec_count 3; subsequent start clears counters and restarts at ADDR_LO.

Source files
------------

// File: rtl/picomips_sweep_driver.sv
`timescale 1ns/1ps
// picomips_sweep_driver
//
// Drives a picoMIPS core through an address sweep. For each address it
// presents the value on the SW data lines, pulses the SW handshake strobe,
// waits for the core to settle, then compares the LED result against a
// synchronous expected-value ROM within a signed tolerance. Optional
// continuous mode wraps the sweep forever. Abort returns to idle and keeps
// the counters.
//
// Ports:
//   clk, n_reset          clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, starts a sweep from IDLE or DONE
//   abort                 synchronous return to IDLE, counters retained
//   cont_mode             wrap from ADDR_HI back to ADDR_LO and keep going
//   sw_data, sw_strobe    stimulus value and handshake towards the core
//   dut_result            signed result from the core (LED lines)
//   exp_addr, exp_data    expected-value ROM address / signed data (1-cycle latency)
//   busy, done            status: sweeping / finished
//   vec_count, err_count  vectors checked / vectors failed, saturating
//   fail_seen             at least one failure since the last start
//   first_fail_addr       address of the first failure since the last start
module picomips_sweep_driver #(
    parameter int DATA_W        = 8,
    parameter int ADDR_LO       = 0,
    parameter int ADDR_HI       = 254,
    parameter int SETUP_CYCLES  = 10,
    parameter int HOLD_CYCLES   = 30,
    parameter int SETTLE_CYCLES = 5,
    parameter int TOL           = 0,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     cont_mode,
    output logic [DATA_W-1:0]        sw_data,
    output logic                     sw_strobe,
    input  logic signed [DATA_W-1:0] dut_result,
    output logic [DATA_W-1:0]        exp_addr,
    input  logic signed [DATA_W-1:0] exp_data,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         vec_count,
    output logic [CNT_W-1:0]         err_count,
    output logic                     fail_seen,
    output logic [DATA_W-1:0]        first_fail_addr
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SETTLE, CHECK, DONE} state_t;

    localparam int TMR_MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int TMR_MAX    = (TMR_MAX_SH > SETTLE_CYCLES) ? TMR_MAX_SH : SETTLE_CYCLES;
    localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  SETUP_LAST  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [DATA_W-1:0] A_LO        = DATA_W'(ADDR_LO);
    localparam logic [DATA_W-1:0] A_HI        = DATA_W'(ADDR_HI);
    localparam logic [DATA_W:0]   TOL_V       = (DATA_W+1)'(TOL);

    // Both operands are widened by one bit so that e.g. 0x7F vs 0x80 gives
    // a magnitude of 255 rather than wrapping to 1.
    function automatic logic [DATA_W:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return d[DATA_W] ? -d : d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [DATA_W-1:0]   addr, addr_nxt;
    logic                clr, chk_en, cap;
    logic signed [DATA_W-1:0] res_p1, exp_p1;
    logic                fail_p1;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + 1'b1;
        addr_nxt  = addr;
        clr       = 1'b0;
        chk_en    = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE, DONE: begin
                tmr_nxt = '0;
                if (start) begin
                    state_nxt = SETUP;
                    clr       = 1'b1;
                    addr_nxt  = A_LO;
                end
            end
            SETUP: begin
                if (tmr == SETUP_LAST) begin
                    state_nxt = STROBE;
                    tmr_nxt   = '0;
                end
            end
            STROBE: begin
                if (tmr == HOLD_LAST) begin
                    state_nxt = SETTLE;
                    tmr_nxt   = '0;
                end
            end
            SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    cap       = 1'b1;
                    state_nxt = CHECK;
                    tmr_nxt   = '0;
                end
            end
            CHECK: begin
                chk_en  = 1'b1;
                tmr_nxt = '0;
                if (addr < A_HI) begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = SETUP;
                end else if (cont_mode) begin
                    addr_nxt  = A_LO;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
        // Abort overrides everything, including the update of an in-flight check.
        if (abort) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
            addr_nxt  = addr;
            clr       = 1'b0;
            chk_en    = 1'b0;
            cap       = 1'b0;
        end
    end

    // Stage p1: sample result and expected value at the end of settle
    always_ff @(posedge clk) begin
        if (cap) begin
            res_p1 <= dut_result;
            exp_p1 <= exp_data;
        end
    end

    assign fail_p1 = abs_diff(res_p1, exp_p1) > TOL_V;

    // Stage p2: control state, counters and registered status outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            tmr             <= '0;
            addr            <= A_LO;
            sw_strobe       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_count       <= '0;
            err_count       <= '0;
            fail_seen       <= 1'b0;
            first_fail_addr <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            addr      <= addr_nxt;
            sw_strobe <= (state_nxt == STROBE);
            busy      <= (state_nxt != IDLE) && (state_nxt != DONE);
            done      <= (state_nxt == DONE);
            if (clr) begin
                vec_count       <= '0;
                err_count       <= '0;
                fail_seen       <= 1'b0;
                first_fail_addr <= '0;
            end else if (chk_en) begin
                vec_count <= sat_inc(vec_count);
                if (fail_p1) begin
                    err_count <= sat_inc(err_count);
                    if (!fail_seen) begin
                        fail_seen       <= 1'b1;
                        first_fail_addr <= addr;
                    end
                end
            end
        end
    end

    // addr only moves on entry to SETUP, so stimulus is frozen while strobing.
    assign sw_data  = addr;
    assign exp_addr = addr;

endmodule

// File: tb/tb_picomips_sweep_driver.sv
`timescale 1ns/1ps
module tb_picomips_sweep_driver;

    localparam int PERIOD = 46;
    localparam int NVEC   = 255;
    localparam int SETUP  = 10;
    localparam int HOLD   = 30;
    localparam int LIMIT  = NVEC * PERIOD + 100;

    logic clk     = 1'b1;
    logic n_reset = 1'b1;
    logic start   = 1'b0;
    logic abort   = 1'b0;
    logic cont0   = 1'b0;
    logic cont1   = 1'b1;
    logic corrupt = 1'b0;
    logic model_en = 1'b0;
    logic d_done_seen = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a * 8'd37 + 8'd11;
    endfunction

    function automatic logic [7:0] corr_f(input logic [7:0] a);
        if (a == 8'd7)   return 8'd3;
        if (a == 8'd200) return 8'hFF;
        return 8'd0;
    endfunction

    // ---------------- instance A: defaults, main model-checked DUT
    logic [7:0]  sw_a, ea_a, ff_a, exp_a, dut_a;
    logic        stb_a, busy_a, done_a, fs_a;
    logic [15:0] vec_a, err_a;
    always @(posedge clk) exp_a <= rom_f(ea_a);
    assign dut_a = rom_f(sw_a) + (corrupt ? corr_f(sw_a) : 8'd0);

    picomips_sweep_driver u_a (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .cont_mode(cont0),
        .sw_data(sw_a), .sw_strobe(stb_a), .dut_result(dut_a), .exp_addr(ea_a),
        .exp_data(exp_a), .busy(busy_a), .done(done_a), .vec_count(vec_a),
        .err_count(err_a), .fail_seen(fs_a), .first_fail_addr(ff_a));

    // ---------------- instance B: TOL=3, core always corrupted
    logic [7:0]  sw_b, ea_b, ff_b, exp_b, dut_b;
    logic        stb_b, busy_b, done_b, fs_b;
    logic [15:0] vec_b, err_b;
    always @(posedge clk) exp_b <= rom_f(ea_b);
    assign dut_b = rom_f(sw_b) + corr_f(sw_b);

    picomips_sweep_driver #(.TOL(3)) u_b (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .cont_mode(cont0),
        .sw_data(sw_b), .sw_strobe(stb_b), .dut_result(dut_b), .exp_addr(ea_b),
        .exp_data(exp_b), .busy(busy_b), .done(done_b), .vec_count(vec_b),
        .err_count(err_b), .fail_seen(fs_b), .first_fail_addr(ff_b));

    // ---------------- instance C: single vector at 5, signed edge 0x7F vs 0x80, TOL=1
    logic [7:0]  sw_c, ea_c, ff_c, exp_c, dut_c;
    logic        stb_c, busy_c, done_c, fs_c;
    logic [15:0] vec_c, err_c;
    always @(posedge clk) exp_c <= 8'h7F;
    assign dut_c = 8'h80;

    picomips_sweep_driver #(.ADDR_LO(5), .ADDR_HI(5), .TOL(1)) u_c (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .cont_mode(cont0),
        .sw_data(sw_c), .sw_strobe(stb_c), .dut_result(dut_c), .exp_addr(ea_c),
        .exp_data(exp_c), .busy(busy_c), .done(done_c), .vec_count(vec_c),
        .err_count(err_c), .fail_seen(fs_c), .first_fail_addr(ff_c));

    // ---------------- instance D: continuous sweep 250..254
    logic [7:0]  sw_d, ea_d, ff_d, exp_d, dut_d;
    logic        stb_d, busy_d, done_d, fs_d;
    logic [15:0] vec_d, err_d;
    always @(posedge clk) exp_d <= rom_f(ea_d);
    assign dut_d = rom_f(sw_d);

    picomips_sweep_driver #(.ADDR_LO(250), .ADDR_HI(254)) u_d (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .cont_mode(cont1),
        .sw_data(sw_d), .sw_strobe(stb_d), .dut_result(dut_d), .exp_addr(ea_d),
        .exp_data(exp_d), .busy(busy_d), .done(done_d), .vec_count(vec_d),
        .err_count(err_d), .fail_seen(fs_d), .first_fail_addr(ff_d));

    always @(negedge clk) if (model_en && n_reset && done_d) d_done_seen <= 1'b1;

    // ---------------- behavioural model of instance A
    typedef struct packed {
        logic [7:0]  sw;
        logic [7:0]  ea;
        logic        stb;
        logic        busy;
        logic        done;
        logic [15:0] vec;
        logic [15:0] err;
        logic        fs;
        logic [7:0]  ff;
    } obs_t;

    // Outputs k cycles after the start edge of an uninterrupted sweep 0..254.
    function automatic obs_t model_at(input int k, input bit corr);
        obs_t o;
        int v, p, nb;
        v = k / PERIOD;
        p = k % PERIOD;
        o = '0;
        if (v >= NVEC) begin
            v      = NVEC;
            o.sw   = 8'(NVEC - 1);
            o.done = 1'b1;
        end else begin
            o.sw   = 8'(v);
            o.busy = 1'b1;
            o.stb  = (p >= SETUP) && (p < SETUP + HOLD);
        end
        o.ea  = o.sw;
        nb    = corr ? (((v > 7) ? 1 : 0) + ((v > 200) ? 1 : 0)) : 0;
        o.vec = 16'(v);
        o.err = 16'(nb);
        o.fs  = (nb > 0);
        o.ff  = (nb > 0) ? 8'd7 : 8'd0;
        return o;
    endfunction

    int   m_mode = 0;     // 0 idle since reset, 1 sweeping/done, 2 idle after abort
    int   m_k    = 0;
    bit   m_corr = 1'b0;
    obs_t m_frozen;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_mode <= 0;
        end else if (abort) begin
            if (m_mode == 1) begin
                m_frozen      <= model_at(m_k, m_corr);
                m_frozen.stb  <= 1'b0;
                m_frozen.busy <= 1'b0;
                m_frozen.done <= 1'b0;
                m_mode        <= 2;
            end
        end else if (start && (m_mode != 1 || m_k >= NVEC * PERIOD)) begin
            m_mode <= 1;
            m_k    <= 0;
            m_corr <= corrupt;
        end else if (m_mode == 1) begin
            m_k <= m_k + 1;
        end
    end

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    always @(negedge clk) begin
        obs_t act, ex;
        if (model_en && n_reset) begin
            act = {sw_a, ea_a, stb_a, busy_a, done_a, vec_a, err_a, fs_a, ff_a};
            if (m_mode == 1)      ex = model_at(m_k, m_corr);
            else if (m_mode == 2) ex = m_frozen;
            else                  ex = '0;
            n_chk++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL model_a t=%0t: got %h expected %h", $time, act, ex);
                if (n_fail >= 200) begin
                    report();
                    $finish;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
            if (n_fail >= 200) begin
                report();
                $finish;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after pulse_start; n counts cycles from the start edge.
    task automatic wait_done(input bit with_d, output int n);
        n = 0;
        while (done_a !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (with_d && n == 4 * PERIOD)  check("cont_sw_254", 32'(sw_d), 32'd254);
            if (with_d && n == 5 * PERIOD)  check("cont_wrap_250", 32'(sw_d), 32'd250);
            if (with_d && n == 10 * PERIOD) check("cont_vec_10", 32'(vec_d), 32'd10);
        end
    endtask

    initial begin
        int n;
        #5 n_reset = 1'b0;
        #7;
        check("rst_sw_a", 32'(sw_a), 32'd0);
        check("rst_ea_a", 32'(ea_a), 32'd0);
        check("rst_stb_a", 32'(stb_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_vec_a", 32'(vec_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_fs_a", 32'(fs_a), 32'd0);
        check("rst_ff_a", 32'(ff_a), 32'd0);
        check("rst_sw_c", 32'(sw_c), 32'd5);
        check("rst_ea_d", 32'(ea_d), 32'd250);
        #3 n_reset = 1'b1;
        model_en = 1'b1;

        repeat (20) @(negedge clk);
        check("idle_no_start", 32'(busy_a), 32'd0);

        // clean sweep
        corrupt = 1'b0;
        pulse_start();
        check("s1_busy_first", 32'(busy_a), 32'd1);
        check("s1_sw_first", 32'(sw_a), 32'd0);
        wait_done(1'b1, n);
        check("s1_cycles", 32'(n), 32'(NVEC * PERIOD));
        check("s1_done", 32'(done_a), 32'd1);
        check("s1_busy", 32'(busy_a), 32'd0);
        check("s1_vec", 32'(vec_a), 32'd255);
        check("s1_err", 32'(err_a), 32'd0);
        check("s1_fs", 32'(fs_a), 32'd0);
        check("tol3_vec", 32'(vec_b), 32'd255);
        check("tol3_err", 32'(err_b), 32'd0);
        check("signed_done", 32'(done_c), 32'd1);
        check("signed_vec", 32'(vec_c), 32'd1);
        check("signed_err", 32'(err_c), 32'd1);
        check("signed_fs", 32'(fs_c), 32'd1);
        check("signed_ff", 32'(ff_c), 32'd5);
        check("cont_busy", 32'(busy_d), 32'd1);
        check("cont_no_done", 32'(d_done_seen), 32'd0);

        // corrupted sweep: +3 at 7, -1 at 200
        corrupt = 1'b1;
        pulse_start();
        wait_done(1'b0, n);
        check("s2_cycles", 32'(n), 32'(NVEC * PERIOD));
        check("s2_vec", 32'(vec_a), 32'd255);
        check("s2_err", 32'(err_a), 32'd2);
        check("s2_fs", 32'(fs_a), 32'd1);
        check("s2_ff", 32'(ff_a), 32'd7);
        check("s2_tol3_err", 32'(err_b), 32'd0);
        check("s2_tol3_fs", 32'(fs_b), 32'd0);

        // abort during strobe of vector 3
        corrupt = 1'b0;
        pulse_start();
        repeat (3 * PERIOD + 15) @(negedge clk);
        check("ab_pre_strobe", 32'(stb_a), 32'd1);
        check("ab_pre_sw", 32'(sw_a), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_strobe", 32'(stb_a), 32'd0);
        check("ab_busy", 32'(busy_a), 32'd0);
        check("ab_done", 32'(done_a), 32'd0);
        check("ab_vec", 32'(vec_a), 32'd3);
        check("ab_err_cleared", 32'(err_a), 32'd0);
        check("ab_cont_idle", 32'(busy_d), 32'd0);
        repeat (10) @(negedge clk);
        check("ab_hold_vec", 32'(vec_a), 32'd3);
        check("ab_hold_busy", 32'(busy_a), 32'd0);

        // restart after abort
        pulse_start();
        check("rs_vec", 32'(vec_a), 32'd0);
        check("rs_sw", 32'(sw_a), 32'd0);
        check("rs_busy", 32'(busy_a), 32'd1);
        check("rs_cont_sw", 32'(sw_d), 32'd250);

        // asynchronous reset while strobing
        repeat (20) @(negedge clk);
        check("mr_pre_strobe", 32'(stb_a), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        check("mr_strobe", 32'(stb_a), 32'd0);
        check("mr_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        check("mr_idle", 32'(busy_a), 32'd0);

        report();
        $finish;
    end

endmodule
